wb_stage: RTL and testbench

Write-back stage; the writer end of the register-file interface that the decode stage reads.
- Accepts completed execute/memory results.
- Waits on multi-cycle data-memory reads.
- Aligns and extends load data.
- Drives busW/F_busW, the destination register and the one-cycle write strobes into the GPR and FPR files.
- Keeps a retired-instruction counter.

---
 rtl/wb_stage.sv | 249 ++++++++++++++++++++++++
 tb/tb_wb_stage.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- write-back stage, the writer end of the GPR/FPR register files.
//
// Accepts completed execute/memory results, waits on multi-cycle data-memory
// reads, aligns and extends load data, and drives the register-file write port
// with one-cycle strobes. Also counts retired instructions.
//
// Ports:
//   clk, reset           clock; synchronous active-low reset
//   in_valid / in_ready  upstream handshake (in_ready is registered)
//   alu_result           ALU result, or memory address for loads
//   fpu_result           FPU result
//   pc                   instruction PC (JAL link value source)
//   dst_reg              destination register index
//   reg_wr, f_reg_wr     GPR / FPR write requested
//   mem_to_reg           load instruction
//   mem_byte_op          byte load
//   mem_halfword_op      halfword load
//   mem_sign_ext         sign-extend load data
//   jal_instr            JAL instruction (writes link register)
//   mem_rdata/mem_rvalid data-memory read return
//   bus_w, fbus_w        GPR / FPR write data
//   w_reg                write register index
//   reg_wr_out           GPR write strobe (one cycle)
//   f_reg_wr_out         FPR write strobe (one cycle)
//   retire_count         completed-instruction count (wraps)
// -----------------------------------------------------------------------------
module wb_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int LINK_OFFSET = 8,
  parameter int LINK_REG    = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     fpu_result,
  input  logic [DATA_W-1:0]     pc,
  input  logic [REG_ADDR_W-1:0] dst_reg,
  input  logic                  reg_wr,
  input  logic                  f_reg_wr,
  input  logic                  mem_to_reg,
  input  logic                  mem_byte_op,
  input  logic                  mem_halfword_op,
  input  logic                  mem_sign_ext,
  input  logic                  jal_instr,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic [DATA_W-1:0]     bus_w,
  output logic [DATA_W-1:0]     fbus_w,
  output logic [REG_ADDR_W-1:0] w_reg,
  output logic                  reg_wr_out,
  output logic                  f_reg_wr_out,
  output logic [31:0]           retire_count
);

  localparam logic [REG_ADDR_W-1:0] LINK_IDX = REG_ADDR_W'(LINK_REG);
  localparam logic [DATA_W-1:0]     LINK_ADD = DATA_W'(LINK_OFFSET);

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_t;

  // Byte 0 is the most significant byte of the word (big-endian lanes).
  function automatic logic [DATA_W-1:0] align_load(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        off,
    input logic              byte_op,
    input logic              half_op,
    input logic              sign_ext
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] res;
    b   = 8'h00;
    h   = 16'h0000;
    res = word;
    if (byte_op) begin
      case (off)
        2'd0:    b = word[DATA_W-1 -: 8];
        2'd1:    b = word[DATA_W-9 -: 8];
        2'd2:    b = word[15:8];
        default: b = word[7:0];
      endcase
      res = {{(DATA_W-8){sign_ext & b[7]}}, b};
    end else if (half_op) begin
      h   = off[1] ? word[15:0] : word[DATA_W-1 -: 16];
      res = {{(DATA_W-16){sign_ext & h[15]}}, h};
    end else begin
      res = word;
    end
    return res;
  endfunction

  state_t                r_state;
  logic                  r_in_ready;
  logic [DATA_W-1:0]     r_bus_w;
  logic [DATA_W-1:0]     r_fbus_w;
  logic [REG_ADDR_W-1:0] r_w_reg;
  logic                  r_reg_wr_out;
  logic                  r_f_reg_wr_out;
  logic [31:0]           r_retire_count;

  // Load context captured at acceptance, used when the read data returns.
  logic [DATA_W-1:0]     r_pc;
  logic [REG_ADDR_W-1:0] r_dst_reg;
  logic [1:0]            r_off;
  logic                  r_reg_wr;
  logic                  r_f_reg_wr;
  logic                  r_byte_op;
  logic                  r_half_op;
  logic                  r_sign_ext;
  logic                  r_jal;

  logic                  w_wait;
  logic                  w_accept;
  logic                  w_complete;
  logic [DATA_W-1:0]     w_sel_pc;
  logic [REG_ADDR_W-1:0] w_sel_dst;
  logic                  w_sel_reg_wr;
  logic                  w_sel_f_reg_wr;
  logic                  w_sel_jal;
  logic [DATA_W-1:0]     w_load_data;
  logic [DATA_W-1:0]     w_gpr_data;
  logic [REG_ADDR_W-1:0] w_gpr_idx;
  logic                  w_gpr_req;
  logic [DATA_W-1:0]     w_fpr_data;

  // Completion source: live inputs for a non-load in IDLE, captured context
  // when a load's data returns.
  always_comb begin
    w_wait      = (r_state == S_WAIT_MEM);
    w_accept    = r_in_ready & in_valid;
    w_load_data = align_load(mem_rdata, r_off, r_byte_op, r_half_op, r_sign_ext);
    if (w_wait) begin
      w_complete     = mem_rvalid;
      w_sel_pc       = r_pc;
      w_sel_dst      = r_dst_reg;
      w_sel_reg_wr   = r_reg_wr;
      w_sel_f_reg_wr = r_f_reg_wr;
      w_sel_jal      = r_jal;
    end else begin
      w_complete     = w_accept & ~mem_to_reg;
      w_sel_pc       = pc;
      w_sel_dst      = dst_reg;
      w_sel_reg_wr   = reg_wr;
      w_sel_f_reg_wr = f_reg_wr;
      w_sel_jal      = jal_instr;
    end
  end

  // Write-port data selection; JAL overrides the GPR destination and request.
  always_comb begin
    if (w_sel_jal) begin
      w_gpr_data = w_sel_pc + LINK_ADD;
      w_gpr_idx  = LINK_IDX;
      w_gpr_req  = 1'b1;
    end else begin
      w_gpr_data = w_wait ? w_load_data : alu_result;
      w_gpr_idx  = w_sel_dst;
      w_gpr_req  = w_sel_reg_wr;
    end
    w_fpr_data = w_wait ? mem_rdata : fpu_result;
  end

  // Stage state, handshake, write port and retire counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_in_ready     <= 1'b0;
      r_bus_w        <= '0;
      r_fbus_w       <= '0;
      r_w_reg        <= '0;
      r_reg_wr_out   <= 1'b0;
      r_f_reg_wr_out <= 1'b0;
      r_retire_count <= 32'd0;
      r_pc           <= '0;
      r_dst_reg      <= '0;
      r_off          <= 2'd0;
      r_reg_wr       <= 1'b0;
      r_f_reg_wr     <= 1'b0;
      r_byte_op      <= 1'b0;
      r_half_op      <= 1'b0;
      r_sign_ext     <= 1'b0;
      r_jal          <= 1'b0;
    end else begin
      r_reg_wr_out   <= 1'b0;
      r_f_reg_wr_out <= 1'b0;
      if (w_complete) begin
        if (w_gpr_req) begin
          r_bus_w      <= w_gpr_data;
          r_w_reg      <= w_gpr_idx;
          // r0 is hardwired; data still updates but no strobe.
          r_reg_wr_out <= (w_gpr_idx != '0);
        end
        if (w_sel_f_reg_wr) begin
          r_fbus_w       <= w_fpr_data;
          r_f_reg_wr_out <= 1'b1;
        end
        r_retire_count <= r_retire_count + 32'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pc       <= pc;
            r_dst_reg  <= dst_reg;
            r_off      <= alu_result[1:0];
            r_reg_wr   <= reg_wr;
            r_f_reg_wr <= f_reg_wr;
            r_byte_op  <= mem_byte_op;
            r_half_op  <= mem_halfword_op;
            r_sign_ext <= mem_sign_ext;
            r_jal      <= jal_instr;
          end
          if (w_accept && mem_to_reg) begin
            r_state    <= S_WAIT_MEM;
            r_in_ready <= 1'b0;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_WAIT_MEM: begin
          if (mem_rvalid) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
          end else begin
            r_in_ready <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign bus_w        = r_bus_w;
  assign fbus_w       = r_fbus_w;
  assign w_reg        = r_w_reg;
  assign reg_wr_out   = r_reg_wr_out;
  assign f_reg_wr_out = r_f_reg_wr_out;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- scoreboard bench for wb_stage. A driver issues transactions
// and pushes the expected register-file write into a queue; a monitor pops and
// compares whenever a write strobe appears.
// -----------------------------------------------------------------------------
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result, fpu_result, pc;
  logic [4:0]  dst_reg;
  logic        reg_wr, f_reg_wr, mem_to_reg, mem_byte_op, mem_halfword_op;
  logic        mem_sign_ext, jal_instr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] bus_w, fbus_w;
  logic [4:0]  w_reg;
  logic        reg_wr_out, f_reg_wr_out;
  logic [31:0] retire_count;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .fpu_result(fpu_result), .pc(pc),
    .dst_reg(dst_reg), .reg_wr(reg_wr), .f_reg_wr(f_reg_wr),
    .mem_to_reg(mem_to_reg), .mem_byte_op(mem_byte_op),
    .mem_halfword_op(mem_halfword_op), .mem_sign_ext(mem_sign_ext),
    .jal_instr(jal_instr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .bus_w(bus_w), .fbus_w(fbus_w), .w_reg(w_reg), .reg_wr_out(reg_wr_out),
    .f_reg_wr_out(f_reg_wr_out), .retire_count(retire_count)
  );

  typedef struct packed {
    logic [31:0] alu, fpu, pc;
    logic [4:0]  dst;
    logic        reg_wr, f_reg_wr, load, bop, hop, sext, jal;
  } txn_t;

  typedef struct packed {
    logic [31:0] bus, fbus, ret;
    logic [4:0]  wreg;
    logic        gwe, fwe;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_bus  = 32'd0;
  logic [31:0] m_fbus = 32'd0;
  logic [4:0]  m_wreg = 5'd0;
  logic [31:0] m_ret  = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference load extraction: pick the addressed lane by shifting, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic bop, input logic hop, input logic sext);
    logic [31:0] v;
    int          o;
    o = int'(off);
    if (bop) begin
      v = (word >> (8 * (3 - o))) & 32'h0000_00FF;
      if (sext && v >= 32'h0000_0080) v = v | 32'hFFFF_FF00;
    end else if (hop) begin
      v = (word >> ((o >= 2) ? 0 : 16)) & 32'h0000_FFFF;
      if (sext && v >= 32'h0000_8000) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  task automatic model_complete(input txn_t t, input logic [31:0] rdata);
    exp_t e;
    e = '0;
    if (t.jal) begin
      m_bus  = t.pc + 32'd8;
      m_wreg = 5'd31;
      e.gwe  = 1'b1;
    end else if (t.reg_wr) begin
      m_bus  = t.load ? ref_load(rdata, t.alu[1:0], t.bop, t.hop, t.sext) : t.alu;
      m_wreg = t.dst;
      e.gwe  = (t.dst != 5'd0);
    end
    if (t.f_reg_wr) begin
      m_fbus = t.load ? rdata : t.fpu;
      e.fwe  = 1'b1;
    end
    m_ret  = m_ret + 32'd1;
    e.bus  = m_bus;
    e.fbus = m_fbus;
    e.wreg = m_wreg;
    e.ret  = m_ret;
    if (e.gwe || e.fwe) exp_q.push_back(e);
  endtask

  task automatic drive(input txn_t t);
    alu_result      = t.alu;
    fpu_result      = t.fpu;
    pc              = t.pc;
    dst_reg         = t.dst;
    reg_wr          = t.reg_wr;
    f_reg_wr        = t.f_reg_wr;
    mem_to_reg      = t.load;
    mem_byte_op     = t.bop;
    mem_halfword_op = t.hop;
    mem_sign_ext    = t.sext;
    jal_instr       = t.jal;
  endtask

  task automatic scramble();
    alu_result = $urandom;
    fpu_result = $urandom;
    pc         = $urandom;
    dst_reg    = 5'($urandom_range(0, 31));
    reg_wr     = 1'($urandom_range(0, 1));
    f_reg_wr   = 1'($urandom_range(0, 1));
    jal_instr  = 1'($urandom_range(0, 1));
    mem_sign_ext = 1'($urandom_range(0, 1));
  endtask

  // Issue one transaction starting just after a falling edge; returns at the
  // falling edge after the completion edge.
  task automatic do_txn(input txn_t t, input int lat, input logic [31:0] rdata);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    drive(t);
    in_valid   = 1'b1;
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
    @(posedge clk);
    if (!t.load) model_complete(t, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    if (t.load) begin
      mem_rvalid = 1'b0;
      for (int i = 0; i < lat; i++) begin
        scramble();
        in_valid = 1'($urandom_range(0, 1));
        check("in_ready_wait_mem", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
      end
      check("in_ready_wait_mem", {31'd0, in_ready}, 32'd0);
      scramble();
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      @(posedge clk);
      model_complete(t, rdata);
      @(negedge clk);
      mem_rvalid = 1'b0;
      in_valid   = 1'b0;
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (reg_wr_out || f_reg_wr_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: actual gpr=%0b fpr=%0b required none", reg_wr_out, f_reg_wr_out);
      end else begin
        e = exp_q.pop_front();
        check("sb_reg_wr_out", {31'd0, reg_wr_out}, {31'd0, e.gwe});
        check("sb_f_reg_wr_out", {31'd0, f_reg_wr_out}, {31'd0, e.fwe});
        check("sb_bus_w", bus_w, e.bus);
        check("sb_fbus_w", fbus_w, e.fbus);
        check("sb_w_reg", {27'd0, w_reg}, {27'd0, e.wreg});
        check("sb_retire_count", retire_count, e.ret);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t t;
    reset = 1'b0; in_valid = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    t = '0;
    drive(t);

    // Reset held two cycles.
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_bus_w", bus_w, 32'd0);
    check("rst_fbus_w", fbus_w, 32'd0);
    check("rst_w_reg", {27'd0, w_reg}, 32'd0);
    check("rst_strobes", {30'd0, reg_wr_out, f_reg_wr_out}, 32'd0);
    check("rst_retire", retire_count, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("in_ready_after_release", {31'd0, in_ready}, 32'd1);

    // add r3 = 5
    t = '0; t.alu = 32'd5; t.dst = 5'd3; t.reg_wr = 1'b1;
    do_txn(t, 0, 32'd0);
    check("add_bus_w", bus_w, 32'd5);
    @(negedge clk);
    check("strobe_single_cycle", {31'd0, reg_wr_out}, 32'd0);

    // Byte loads, signed and unsigned.
    t = '0; t.alu = 32'h0000_1001; t.dst = 5'd4; t.reg_wr = 1'b1; t.load = 1'b1;
    t.bop = 1'b1; t.sext = 1'b1;
    do_txn(t, 2, 32'h12F4_5678);
    check("lb_signed", bus_w, 32'hFFFF_FFF4);
    t.sext = 1'b0;
    do_txn(t, 2, 32'h12F4_5678);
    check("lb_unsigned", bus_w, 32'h0000_00F4);

    // Halfword loads at both halves.
    t = '0; t.alu = 32'h0000_2002; t.dst = 5'd6; t.reg_wr = 1'b1; t.load = 1'b1;
    t.hop = 1'b1; t.sext = 1'b1;
    do_txn(t, 0, 32'hAAAA_8001);
    check("lh_off2", bus_w, 32'hFFFF_8001);
    t.alu = 32'h0000_2000;
    do_txn(t, 1, 32'hAAAA_8001);
    check("lh_off0", bus_w, 32'hFFFF_AAAA);

    // JAL link, then a write to r0.
    t = '0; t.pc = 32'h0040_0010; t.dst = 5'd7; t.jal = 1'b1;
    do_txn(t, 0, 32'd0);
    check("jal_bus_w", bus_w, 32'h0040_0018);
    check("jal_w_reg", {27'd0, w_reg}, 32'd31);
    check("jal_strobe", {31'd0, reg_wr_out}, 32'd1);
    t = '0; t.alu = 32'd9; t.dst = 5'd0; t.reg_wr = 1'b1;
    do_txn(t, 0, 32'd0);
    check("r0_bus_w", bus_w, 32'd9);
    check("r0_no_strobe", {31'd0, reg_wr_out}, 32'd0);

    // Retire counter wrap with four back-to-back transfers.
    force dut.r_retire_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_retire_count;
    m_ret = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      t = '0; t.alu = $urandom; t.dst = 5'(i + 10); t.reg_wr = 1'b1;
      do_txn(t, 0, 32'd0);
      check("b2b_strobe", {31'd0, reg_wr_out}, 32'd1);
    end
    check("wrap_count", retire_count, 32'd2);

    // Randomized mix.
    for (int k = 0; k < 150; k++) begin
      t.alu      = $urandom;
      t.fpu      = $urandom;
      t.pc       = $urandom;
      t.dst      = 5'($urandom_range(0, 31));
      t.reg_wr   = 1'($urandom_range(0, 1));
      t.f_reg_wr = 1'($urandom_range(0, 1));
      t.load     = ($urandom_range(0, 9) < 4);
      t.bop      = 1'($urandom_range(0, 1));
      t.hop      = 1'($urandom_range(0, 1));
      t.sext     = 1'($urandom_range(0, 1));
      t.jal      = ($urandom_range(0, 9) == 0);
      do_txn(t, int'($urandom_range(0, 3)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset while waiting on a load; data arriving afterwards is ignored.
    @(negedge clk);
    t = '0; t.alu = 32'h0000_3000; t.dst = 5'd9; t.reg_wr = 1'b1; t.f_reg_wr = 1'b1; t.load = 1'b1;
    drive(t);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("wait_before_reset", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    m_bus = 32'd0; m_fbus = 32'd0; m_wreg = 5'd0; m_ret = 32'd0;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_bus_w", bus_w, 32'd0);
    check("post_rst_fbus_w", fbus_w, 32'd0);
    check("post_rst_strobes", {30'd0, reg_wr_out, f_reg_wr_out}, 32'd0);
    check("post_rst_retire", retire_count, 32'd0);
    @(negedge clk);
    check("post_rst_no_strobe", {30'd0, reg_wr_out, f_reg_wr_out}, 32'd0);

    // Stage is usable again after the abandoned load.
    t = '0; t.fpu = 32'h3F80_0000; t.dst = 5'd0; t.f_reg_wr = 1'b1;
    do_txn(t, 0, 32'd0);
    check("fpr_r0_fbus_w", fbus_w, 32'h3F80_0000);
    check("fpr_r0_strobe", {31'd0, f_reg_wr_out}, 32'd1);
    repeat (2) @(negedge clk);

    check("final_retire", retire_count, m_ret);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
